// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver tapping a serial line, followed by a first-word-fall-through byte FIFO
// read through a valid/ready port. dbg_state exposes the receiver FSM for checkers.
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       uart_rx_input,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [2:0]                 dbg_state
);

  // Read port handshake: a byte is transferred on every rising clock edge where
  // rd_valid and rd_ready are both 1; rd_ready while rd_valid is 0 has no effect,
  // and rd_data is stable at the FIFO head for as long as rd_valid stays 1.

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = AW + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  rx_state_t      state;
  logic           rx_meta;
  logic           rx_s;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           push_r;
  logic [7:0]     push_data;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [NW-1:0]  count;
  logic           pop;
  logic           push_ok;
  logic           push_drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_input;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_r    <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_r    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              push_r    <= 1'b1;
              push_data <= shift;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // A held-low line (break) must return high before a new start is accepted.
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  assign rd_valid  = (count != '0);
  assign pop       = rd_valid & rd_ready;
  assign push_ok   = push_r & ((count != FULL_CNT) | pop);
  assign push_drop = push_r & (count == FULL_CNT) & ~pop;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      if (push_drop)           overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign fifo_count = count;
  assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;

endmodule
